// File: rtl/sound_sequencer.sv
// Frame-based sequencer that plays a stored program of sound-generator parameter frames.
// Each frame holds its settings for duration x CLK_DIV cycles, then advances or ends.
module sound_sequencer #(
   parameter int CLK_DIV = 250000,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [47:0]       wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [11:0]       vco_freq,
   output logic [11:0]       noise_freq,
   output logic [9:0]        lfo_freq,
   output logic [2:0]        lfo_shift,
   output logic              vco_select,
   output logic              noise_select,
   output logic [2:0]        mixer
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PW    = $clog2(CLK_DIV);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PLAY = 1'b1;

   logic [47:0]       r_mem [DEPTH];
   logic [0:0]        r_state;
   logic [PW-1:0]     r_presc;
   logic [5:0]        r_remain;
   logic              r_last;
   logic              r_busy;
   logic              r_done;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [11:0]       r_vco_freq;
   logic [11:0]       r_noise_freq;
   logic [9:0]        r_lfo_freq;
   logic [2:0]        r_lfo_shift;
   logic              r_vco_select;
   logic              r_noise_select;
   logic [2:0]        r_mixer;

   logic [ADDR_W-1:0] w_fetch_addr;
   logic [47:0]       w_frame;
   logic [4:0]        w_dur;
   logic              w_tick;
   logic              w_frame_end;
   logic              w_load;
   logic              w_finish;

   // NOTE: program memory has no reset; a reset only clears the playback state.
   always_ff @(posedge clk) begin
      if (wr_en)
         r_mem[wr_addr] <= wr_data;
   end

   // Combinational fetch: a same-cycle write is not yet visible, so old data is read.
   assign w_fetch_addr = start ? start_addr : r_cur_addr + ADDR_W'(1);
   assign w_frame      = r_mem[w_fetch_addr];
   assign w_dur        = w_frame[46:42];
   assign w_tick       = (r_state == S_PLAY) && (r_presc == PW'(CLK_DIV - 1));
   assign w_frame_end  = w_tick && (r_remain == 6'd1);

   // Priority: stop > start > frame advance.
   assign w_load   = !stop && (start || (w_frame_end && !r_last));
   assign w_finish = !stop && !start && w_frame_end && r_last;

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_presc        <= '0;
         r_remain       <= '0;
         r_last         <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_cur_addr     <= '0;
         r_vco_freq     <= '0;
         r_noise_freq   <= '0;
         r_lfo_freq     <= '0;
         r_lfo_shift    <= '0;
         r_vco_select   <= 1'b0;
         r_noise_select <= 1'b0;
         r_mixer        <= '0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_mixer <= '0;
         end else if (w_load) begin
            r_state        <= S_PLAY;
            r_busy         <= 1'b1;
            r_presc        <= '0;
            r_remain       <= (w_dur == 5'd0) ? 6'd32 : {1'b0, w_dur};
            r_last         <= w_frame[47];
            r_cur_addr     <= w_fetch_addr;
            r_noise_select <= w_frame[41];
            r_vco_select   <= w_frame[40];
            r_mixer        <= w_frame[39:37];
            r_lfo_shift    <= w_frame[36:34];
            r_lfo_freq     <= w_frame[33:24];
            r_noise_freq   <= w_frame[23:12];
            r_vco_freq     <= w_frame[11:0];
         end else if (w_finish) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_mixer <= '0;
            r_done  <= 1'b1;
         end else if (r_state == S_PLAY) begin
            if (w_tick) begin
               r_presc  <= '0;
               r_remain <= r_remain - 6'd1;
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign cur_addr     = r_cur_addr;
   assign vco_freq     = r_vco_freq;
   assign noise_freq   = r_noise_freq;
   assign lfo_freq     = r_lfo_freq;
   assign lfo_shift    = r_lfo_shift;
   assign vco_select   = r_vco_select;
   assign noise_select = r_noise_select;
   assign mixer        = r_mixer;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: a vector table for a single-frame effect,
// then hand-written sequences for wrap, long duration, stop/retrigger, live writes and reset.
module tb_sound_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [47:0] wr_data;
   logic        start;
   logic [3:0]  start_addr;
   logic        stop;
   logic        busy;
   logic        done;
   logic [3:0]  cur_addr;
   logic [11:0] vco_freq;
   logic [11:0] noise_freq;
   logic [9:0]  lfo_freq;
   logic [2:0]  lfo_shift;
   logic        vco_select;
   logic        noise_select;
   logic [2:0]  mixer;

   int n_checks = 0;
   int n_errors = 0;

   sound_sequencer #(.CLK_DIV(4), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .start_addr(start_addr), .stop(stop), .busy(busy), .done(done),
      .cur_addr(cur_addr), .vco_freq(vco_freq), .noise_freq(noise_freq), .lfo_freq(lfo_freq),
      .lfo_shift(lfo_shift), .vco_select(vco_select), .noise_select(noise_select), .mixer(mixer)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [47:0] wr_data;
      logic        start;
      logic [3:0]  start_addr;
      logic        stop;
      logic        exp_busy;
      logic        exp_done;
      logic [3:0]  exp_cur;
      logic [2:0]  exp_mixer;
      logic [11:0] exp_vco;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [47:0] mk(input logic last, input logic [4:0] dur, input logic nsel,
                                      input logic vsel, input logic [2:0] mix, input logic [2:0] shift,
                                      input logic [9:0] lfo, input logic [11:0] noise, input logic [11:0] vco);
      return {last, dur, nsel, vsel, mix, shift, lfo, noise, vco};
   endfunction

   function automatic void add(input logic we, input logic [3:0] wa, input logic [47:0] wd,
                               input logic st, input logic [3:0] sa, input logic sp,
                               input logic eb, input logic ed, input logic [3:0] ec,
                               input logic [2:0] em, input logic [11:0] ev);
      vec_t v;
      v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.start = st; v.start_addr = sa; v.stop = sp;
      v.exp_busy = eb; v.exp_done = ed; v.exp_cur = ec; v.exp_mixer = em; v.exp_vco = ev;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [47:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic go(input logic [3:0] a);
      start = 1'b1; start_addr = a;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] f2;
      int          k;
      int          n_done;
      logic        bad;

      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; start_addr = '0; stop = 1'b0;
      cyc();
      check("reset_busy", busy, 0);
      check("reset_mixer", mixer, 0);
      check("reset_vco", vco_freq, 0);
      check("reset_cur", cur_addr, 0);
      reset = 1'b0;
      cyc();

      // Single-frame effect: dur=3 -> 12 cycles, then done pulse and stop in IDLE ignored.
      f2 = mk(1'b1, 5'd3, 1'b0, 1'b0, 3'b101, 3'd0, 10'd0, 12'd0, 12'h123);
      add(1'b1, 4'd2, f2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 12'h000);
      add(1'b0, 4'd0, '0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 3'd5, 12'h123);
      for (int i = 1; i < 12; i++)
         add(1'b0, 4'd0, '0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 3'd5, 12'h123);
      add(1'b0, 4'd0, '0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd0, 12'h123);
      add(1'b0, 4'd0, '0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 3'd0, 12'h123);
      add(1'b0, 4'd0, '0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 3'd0, 12'h123);

      foreach (vecs[i]) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         start = vecs[i].start; start_addr = vecs[i].start_addr; stop = vecs[i].stop;
         cyc();
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
         check($sformatf("vec%0d_cur", i), cur_addr, vecs[i].exp_cur);
         check($sformatf("vec%0d_mixer", i), mixer, vecs[i].exp_mixer);
         check($sformatf("vec%0d_vco", i), vco_freq, vecs[i].exp_vco);
      end
      wr_en = 1'b0; start = 1'b0; stop = 1'b0;

      // Wrap 14 -> 15 -> 0 lasting 4, 8, 4 cycles.
      wr(4'd14, mk(1'b0, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h00E));
      wr(4'd15, mk(1'b0, 5'd2, 1'b0, 1'b0, 3'b010, 3'd0, 10'd0, 12'd0, 12'h00F));
      wr(4'd0,  mk(1'b1, 5'd1, 1'b0, 1'b0, 3'b100, 3'd0, 10'd0, 12'd0, 12'h0A0));
      go(4'd14);
      n_done = 0;
      for (int i = 0; i < 18; i++) begin
         check($sformatf("wrap%0d_cur", i), cur_addr, (i < 4) ? 4'd14 : (i < 12) ? 4'd15 : 4'd0);
         check($sformatf("wrap%0d_busy", i), busy, (i < 16) ? 1'b1 : 1'b0);
         check($sformatf("wrap%0d_done", i), done, (i == 16) ? 1'b1 : 1'b0);
         if (done) n_done++;
         cyc();
      end
      check("wrap_done_count", n_done, 1);

      // Duration 0 means 32 ticks = 128 cycles.
      wr(4'd5, mk(1'b1, 5'd0, 1'b1, 1'b1, 3'b111, 3'd3, 10'h2AB, 12'h456, 12'h789));
      go(4'd5);
      k = 0;
      while (k < 200 && !done) begin
         cyc();
         k++;
      end
      check("dur0_cycles", k, 128);
      check("dur0_mixer_after", mixer, 0);

      // stop+start together aborts; later a mid-frame retrigger restarts timing.
      wr(4'd8,  mk(1'b0, 5'd2, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h808));
      wr(4'd9,  mk(1'b0, 5'd2, 1'b0, 1'b0, 3'b010, 3'd0, 10'd0, 12'd0, 12'h909));
      wr(4'd10, mk(1'b1, 5'd2, 1'b0, 1'b0, 3'b011, 3'd0, 10'd0, 12'd0, 12'hA0A));
      go(4'd8);
      cyc(); cyc();
      stop = 1'b1; start = 1'b1; start_addr = 4'd2;
      cyc();
      stop = 1'b0; start = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_mixer", mixer, 0);
      check("abort_done", done, 0);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (done || busy) bad = 1'b1;
      end
      check("abort_quiet", bad, 0);
      go(4'd8);
      cyc(); cyc(); cyc(); cyc();
      go(4'd9);
      n_done = 0;
      for (int i = 0; i < 18; i++) begin
         check($sformatf("retrig%0d_cur", i), cur_addr, (i < 8) ? 4'd9 : 4'd10);
         check($sformatf("retrig%0d_busy", i), busy, (i < 16) ? 1'b1 : 1'b0);
         if (done) n_done++;
         if (i == 16) check("retrig_done_at_end", done, 1);
         cyc();
      end
      check("retrig_done_count", n_done, 1);

      // Write to the next frame one cycle before the advance: new data plays.
      wr(4'd12, mk(1'b0, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h111));
      wr(4'd13, mk(1'b1, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h222));
      go(4'd12);
      cyc(); cyc();
      check("early_wr_vco_pre", vco_freq, 12'h111);
      wr_en = 1'b1; wr_addr = 4'd13;
      wr_data = mk(1'b1, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h333);
      cyc();
      wr_en = 1'b0;
      check("early_wr_vco_cur", vco_freq, 12'h111);
      cyc();
      check("early_wr_cur", cur_addr, 4'd13);
      check("early_wr_vco_new", vco_freq, 12'h333);
      cyc(); cyc(); cyc(); cyc();
      check("early_wr_done", done, 1);

      // Write in the same cycle as the advance: old data plays and holds all frame long.
      wr(4'd13, mk(1'b1, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h222));
      go(4'd12);
      cyc(); cyc(); cyc();
      wr_en = 1'b1; wr_addr = 4'd13;
      wr_data = mk(1'b1, 5'd1, 1'b0, 1'b0, 3'b001, 3'd0, 10'd0, 12'd0, 12'h444);
      cyc();
      wr_en = 1'b0;
      check("same_wr_cur", cur_addr, 4'd13);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (vco_freq !== 12'h222) bad = 1'b1;
         if (i < 3) cyc();
      end
      check("same_wr_vco_held", bad, 0);
      cyc();
      check("same_wr_done", done, 1);
      check("same_wr_busy", busy, 0);

      // Asynchronous reset mid-play, then the program is still intact.
      go(4'd5);
      cyc(); cyc();
      check("pre_reset_mixer", mixer, 3'b111);
      #2 reset = 1'b1;
      #1;
      check("async_busy", busy, 0);
      check("async_mixer", mixer, 0);
      check("async_vco", vco_freq, 0);
      check("async_noise", noise_freq, 0);
      check("async_lfo", lfo_freq, 0);
      check("async_shift", lfo_shift, 0);
      check("async_sel", {vco_select, noise_select}, 0);
      check("async_cur", cur_addr, 0);
      cyc();
      reset = 1'b0;
      cyc();
      go(4'd2);
      check("post_reset_busy", busy, 1);
      check("post_reset_mixer", mixer, 3'b101);
      check("post_reset_vco", vco_freq, 12'h123);
      k = 0;
      while (k < 40 && busy) begin
         cyc();
         k++;
      end
      check("post_reset_len", k, 12);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Upstream control stage for the square-wave/LFO/noise sound generator. Stores a small program of parameter frames. On a trigger, it steps through the frames on a fixed tick and drives the generator's frequency, modulation and mixer inputs.
- Each frame holds the generator settings for a programmed number of ticks. This produces multi-segment effects (sweeps, explosions, chirps) without CPU involvement per segment.
- When idle, the mixer output is 0, so the generator is silent.

Parameters:
- CLK_DIV, 250000, clock cycles per sequencer tick (100 Hz at 25 MHz); legal range ≥2.
- ADDR_W, 4, frame address width; depth = 2**ADDR_W frames.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write one frame into program memory
- wr_addr  in  ADDR_W  frame write address
- wr_data  in  48  frame word (format below)
- start  in  1  single-cycle trigger; begin playing at start_addr
- start_addr  in  ADDR_W  first frame of effect
- stop  in  1  abort playback immediately
- busy  out  1  high while a frame is playing
- done  out  1  one-cycle pulse when an effect ends normally (not on stop/reset)
- cur_addr  out  ADDR_W  frame currently playing
- vco_freq  out  12  generator VCO period
- noise_freq  out  12  generator noise period
- lfo_freq  out  10  generator LFO period
- lfo_shift  out  3  modulation depth
- vco_select  out  1  LFO modulates VCO
- noise_select  out  1  LFO modulates noise
- mixer  out  3  {LFO, noise, VCO} enables

Behaviour:
- Frame format:
  - [47] last
  - [46:42] duration in ticks (0 means 32)
  - [41] noise_select
  - [40] vco_select
  - [39:37] mixer
  - [36:34] lfo_shift
  - [33:24] lfo_freq
  - [23:12] noise_freq
  - [11:0] vco_freq
- Program memory:
  - 2**ADDR_W x 48, written synchronously on wr_en; not cleared by reset.
  - Fetch reads the array combinationally in the same cycle. A write to the address being fetched in the same cycle returns the old data.
- Reset (async): all outputs 0, state IDLE, prescaler 0, remaining count 0.
- States:
  - IDLE:
    - mixer forced to 0; other parameter outputs hold their last values; busy=0.
    - start → PLAY at the next edge.
  - PLAY:
    - busy=1; outputs equal the current frame's fields.
    - Prescaler counts 0..CLK_DIV-1 and a tick fires when it is at CLK_DIV-1.
    - On each tick, remaining decrements.
- Start latency:
  - start is sampled at edge E.
  - At E, all parameter outputs load frame start_addr, cur_addr=start_addr, busy=1, prescaler=0, remaining=duration (0→32).
- Frame end (tick while remaining==1):
  - If last=1: at that edge go IDLE, mixer=0, busy=0, done=1 for exactly one cycle.
  - If last=0: at that edge load frame cur_addr+1 (wraps from 2**ADDR_W-1 to 0), prescaler restarts at 0.
  - Result: every frame lasts exactly duration×CLK_DIV cycles, with no gap between frames.
- start while busy: retrigger; start_addr loads as from IDLE, done is not pulsed.
- stop: at the next edge go IDLE, mixer=0, busy=0, no done; stop in IDLE has no effect.
- Priority in one cycle: stop > start > frame advance. stop+start together → IDLE.
- Writes during PLAY are legal. The current frame's outputs are latched at load and do not change until the next load.
- A program with no last flag loops forever around the memory.

Test Plan (CLK_DIV=4, ADDR_W=4):
- Reset mid-PLAY → all outputs 0 immediately (asynchronous), busy=0; after release, a start still plays the previously written frames.
- Write frame 2 = {last=1, dur=3, mixer=3'b101, vco_freq=12'h123}; pulse start with start_addr=2 → next cycle mixer=5, vco_freq=0x123, busy=1; busy falls and done pulses one cycle exactly 12 cycles later; mixer=0 thereafter.
- Frames 14 (dur=1, last=0), 15 (dur=2, last=0), 0 (dur=1, last=1), start at 14 → cur_addr sequence 14,15,0 lasting 4, 8, 4 cycles; wrap verified; single done at end.
- Frame with dur=0, last=1 → plays 128 cycles before done.
- During PLAY of a 3-frame effect, assert stop and start together → IDLE next cycle, mixer=0, no done; then start alone mid-frame → retrigger, frame timing restarts from 0, no done for the aborted effect.
- During PLAY, write a new value to the next frame's address one cycle before the advance → new data is played. Write to that address in the same cycle as the advance → old data is played, and the current frame's outputs never change mid-frame.
